// File: rtl/axis_maxpool_unpad_serializer.sv
// rtl/axis_maxpool_unpad_serializer.sv - strips edge padding from a wide maxpool beat
// and serializes the surviving words onto a narrow AXI-stream, dropping all-zero-keep chunks.
module axis_maxpool_unpad_serializer #(
  parameter int UNITS        = 8,
  parameter int GROUPS       = 2,
  parameter int WORD_WIDTH   = 8,
  parameter int KERNEL_H_MAX = 3,
  parameter int OUT_WORDS    = 4
) (
  input  logic                                                  aclk,
  input  logic                                                  areset,
  input  logic                                                  s_axis_tvalid,
  output logic                                                  s_axis_tready,
  input  logic [2*GROUPS*(UNITS+KERNEL_H_MAX-1)*WORD_WIDTH-1:0] s_axis_tdata,
  input  logic [2*GROUPS*(UNITS+KERNEL_H_MAX-1)-1:0]            s_axis_tkeep,
  input  logic                                                  s_axis_tlast,
  output logic                                                  m_axis_tvalid,
  input  logic                                                  m_axis_tready,
  output logic [OUT_WORDS*WORD_WIDTH-1:0]                       m_axis_tdata,
  output logic [OUT_WORDS-1:0]                                  m_axis_tkeep,
  output logic                                                  m_axis_tlast
);

  localparam int UE     = UNITS + KERNEL_H_MAX - 1;
  localparam int HALF   = KERNEL_H_MAX / 2;
  localparam int N      = 2 * GROUPS * UNITS;
  localparam int CHUNKS = N / OUT_WORDS;
  localparam int CW     = OUT_WORDS * WORD_WIDTH;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int PADS   = 2 * GROUPS * 2 * HALF;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [N*WORD_WIDTH-1:0] data_q, data_d;
  logic [N-1:0]            keep_q, keep_d;
  logic                    last_q, last_d;

  logic [N*WORD_WIDTH-1:0]        strip_data;
  logic [N-1:0]                   strip_keep;
  logic [PADS*(WORD_WIDTH+1)-1:0] pad_bits;
  logic                           unused_pad;

  // Stripping is pure wiring; padding words and their keep bits never reach the holding register.
  for (genvar gc = 0; gc < 2; gc++) begin : g_copy
    for (genvar gg = 0; gg < GROUPS; gg++) begin : g_group
      for (genvar gu = 0; gu < UNITS; gu++) begin : g_unit
        localparam int K = gc*GROUPS*UNITS + gg*UNITS + gu;
        localparam int F = gc*GROUPS*UE + gg*UE + gu + HALF;
        assign strip_data[K*WORD_WIDTH +: WORD_WIDTH] = s_axis_tdata[F*WORD_WIDTH +: WORD_WIDTH];
        assign strip_keep[K] = s_axis_tkeep[F];
      end
      for (genvar gp = 0; gp < HALF; gp++) begin : g_pad
        localparam int B  = ((gc*GROUPS + gg)*HALF + gp) * 2;
        localparam int FL = gc*GROUPS*UE + gg*UE + gp;
        localparam int FH = gc*GROUPS*UE + gg*UE + UNITS + HALF + gp;
        assign pad_bits[B*(WORD_WIDTH+1) +: WORD_WIDTH+1] =
          {s_axis_tkeep[FL], s_axis_tdata[FL*WORD_WIDTH +: WORD_WIDTH]};
        assign pad_bits[(B+1)*(WORD_WIDTH+1) +: WORD_WIDTH+1] =
          {s_axis_tkeep[FH], s_axis_tdata[FH*WORD_WIDTH +: WORD_WIDTH]};
      end
    end
  end
  assign unused_pad = ^pad_bits;

  logic [CW-1:0]        chunk_data;
  logic [OUT_WORDS-1:0] chunk_keep;
  logic                 in_send, last_chunk, emit, advance, load;

  always_comb begin
    chunk_data = '0;
    chunk_keep = '0;
    for (int j = 0; j < CHUNKS; j++) begin
      if (cnt_q == CNT_W'(j)) begin
        chunk_data = data_q[j*CW +: CW];
        chunk_keep = keep_q[j*OUT_WORDS +: OUT_WORDS];
      end
    end
  end

  assign in_send    = (state_q == SEND);
  assign last_chunk = (cnt_q == CNT_W'(CHUNKS-1));
  // The closing chunk of a tlast beat is forced out so the packet boundary survives.
  assign emit       = (|chunk_keep) || (last_chunk && last_q);
  assign advance    = in_send && (!emit || m_axis_tready);
  assign load       = s_axis_tvalid && s_axis_tready;

  assign s_axis_tready = !areset && (!in_send || (advance && last_chunk));
  assign m_axis_tvalid = in_send && emit;
  assign m_axis_tkeep  = in_send ? chunk_keep : '0;
  assign m_axis_tlast  = in_send && last_q && last_chunk;

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < OUT_WORDS; i++) begin
      if (in_send && chunk_keep[i]) begin
        m_axis_tdata[i*WORD_WIDTH +: WORD_WIDTH] = chunk_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (advance) begin
      if (last_chunk) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (load) begin
      state_d = SEND;
      cnt_d   = '0;
      data_d  = strip_data;
      keep_d  = strip_keep;
      last_d  = s_axis_tlast;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axis_maxpool_unpad_serializer.sv
// tb/tb_axis_maxpool_unpad_serializer.sv - directed bench for axis_maxpool_unpad_serializer
module tb_axis_maxpool_unpad_serializer;

  logic         aclk = 1'b0;
  logic         areset;
  logic         s_tvalid, s_tready, s_tlast;
  logic [319:0] s_tdata;
  logic [39:0]  s_tkeep;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tkeep;

  int errors = 0;
  int checks = 0;

  // Chunk j words for data where flat word f carries value f (units 0 and 9 of each group removed).
  logic [31:0] exp_ch [8] = '{32'h04030201, 32'h08070605, 32'h0E0D0C0B, 32'h1211100F,
                              32'h18171615, 32'h1C1B1A19, 32'h2221201F, 32'h26252423};

  axis_maxpool_unpad_serializer dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int f = 0; f < 40; f++) s_tdata[f*8 +: 8] = base + 8'(f);
  endtask

  function automatic logic [31:0] exp_word(input int j, input logic [7:0] base);
    return exp_ch[j] | {4{base}};
  endfunction

  task automatic edge_slot();
    @(posedge aclk);
    #1;
  endtask

  logic [7:0] emit_pat;
  logic [3:0] rdy_pat;
  int         nrx;
  logic       prev_stall;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        prev_last;

  initial begin
    areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
    edge_slot(); edge_slot();
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_s_ready", s_tready, 0);
    areset = 1'b0;
    edge_slot();

    // 1: full keep, last beat, always ready
    s_tvalid = 1'b1; set_data(8'h00); s_tkeep = '1; s_tlast = 1'b1;
    #1 chk("t1_s_ready_idle", s_tready, 1);
    edge_slot();
    s_tvalid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("t1_valid%0d", j), m_tvalid, 1);
      chk($sformatf("t1_data%0d", j), m_tdata, exp_word(j, 8'h00));
      chk($sformatf("t1_keep%0d", j), m_tkeep, 4'hF);
      chk($sformatf("t1_last%0d", j), m_tlast, (j == 7));
      chk($sformatf("t1_s_ready%0d", j), s_tready, (j == 7));
      edge_slot();
    end
    #1 chk("t1_idle_valid", m_tvalid, 0);

    // 2: stripped words 8..15 have zero keep, not last
    s_tvalid = 1'b1; set_data(8'h00); s_tkeep = 40'hFF_FFF8_07FF; s_tlast = 1'b0;
    emit_pat = 8'b1111_0011;
    #1 chk("t2_s_ready_idle", s_tready, 1);
    edge_slot();
    s_tvalid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("t2_valid%0d", j), m_tvalid, emit_pat[j]);
      if (emit_pat[j]) begin
        chk($sformatf("t2_data%0d", j), m_tdata, exp_word(j, 8'h00));
        chk($sformatf("t2_keep%0d", j), m_tkeep, 4'hF);
      end
      chk($sformatf("t2_last%0d", j), m_tlast, 0);
      chk($sformatf("t2_s_ready%0d", j), s_tready, (j == 7));
      edge_slot();
    end
    #1 chk("t2_idle_valid", m_tvalid, 0);

    // 3: only padding keep set, last beat -> single empty tlast beat
    s_tvalid = 1'b1; set_data(8'h00); s_tkeep = 40'h80_6018_0601; s_tlast = 1'b1;
    #1;
    edge_slot();
    s_tvalid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("t3_valid%0d", j), m_tvalid, (j == 7));
      edge_slot();
      if (j == 6) begin
        #1;
        chk("t3_keep7", m_tkeep, 4'h0);
        chk("t3_last7", m_tlast, 1);
        chk("t3_data7", m_tdata, 0);
      end
    end
    #1 chk("t3_idle_valid", m_tvalid, 0);

    // 4: output backpressure with ready pattern 1,0,0,1
    s_tvalid = 1'b1; set_data(8'h40); s_tkeep = '1; s_tlast = 1'b1;
    #1;
    edge_slot();
    s_tvalid = 1'b0;
    rdy_pat = 4'b1001; nrx = 0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 48 && nrx < 8; cyc++) begin
      m_tready = rdy_pat[cyc % 4];
      #1;
      chk("t4_valid", m_tvalid, 1);
      if (prev_stall) begin
        chk("t4_hold_data", m_tdata, prev_data);
        chk("t4_hold_keep", m_tkeep, prev_keep);
        chk("t4_hold_last", m_tlast, prev_last);
      end
      if (m_tvalid) begin
        chk($sformatf("t4_data%0d", nrx), m_tdata, exp_word(nrx, 8'h40));
        chk($sformatf("t4_last%0d", nrx), m_tlast, (nrx == 7));
        if (m_tready) nrx++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata; prev_keep = m_tkeep; prev_last = m_tlast;
      edge_slot();
    end
    chk("t4_beats", nrx, 8);
    m_tready = 1'b1;
    #1 chk("t4_idle_valid", m_tvalid, 0);

    // 5: back-to-back beats, no bubble
    s_tvalid = 1'b1; set_data(8'h00); s_tkeep = '1; s_tlast = 1'b0;
    #1;
    edge_slot();
    set_data(8'h40); s_tlast = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (j == 8) s_tvalid = 1'b0;
      #1;
      chk($sformatf("t5_valid%0d", j), m_tvalid, 1);
      chk($sformatf("t5_data%0d", j), m_tdata, exp_word(j % 8, (j < 8) ? 8'h00 : 8'h40));
      chk($sformatf("t5_last%0d", j), m_tlast, (j == 15));
      chk($sformatf("t5_s_ready%0d", j), s_tready, (j % 8 == 7));
      edge_slot();
    end
    #1 chk("t5_idle_valid", m_tvalid, 0);

    // 6: reset after chunk 3, then a fresh beat
    s_tvalid = 1'b1; set_data(8'h00); s_tkeep = '1; s_tlast = 1'b1;
    #1;
    edge_slot();
    s_tvalid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1 chk($sformatf("t6_pre_data%0d", j), m_tdata, exp_word(j, 8'h00));
      edge_slot();
    end
    areset = 1'b1;
    #1;
    chk("t6_rst_valid", m_tvalid, 0);
    chk("t6_rst_data", m_tdata, 0);
    chk("t6_rst_keep", m_tkeep, 0);
    chk("t6_rst_last", m_tlast, 0);
    chk("t6_rst_s_ready", s_tready, 0);
    edge_slot();
    areset = 1'b0;
    #1;
    chk("t6_post_valid", m_tvalid, 0);
    chk("t6_post_s_ready", s_tready, 1);
    s_tvalid = 1'b1; set_data(8'h80); s_tlast = 1'b1;
    #1;
    edge_slot();
    s_tvalid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      #1;
      chk($sformatf("t6_valid%0d", j), m_tvalid, 1);
      chk($sformatf("t6_data%0d", j), m_tdata, exp_word(j, 8'h80));
      chk($sformatf("t6_last%0d", j), m_tlast, (j == 7));
      edge_slot();
    end
    #1 chk("t6_idle_valid", m_tvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
